// File: rtl/bram_cam.sv
// BRAM-based CAM for the L2 MAC table: per-slice RAMs hold per-entry match bitmaps,
// slices are ANDed and priority-encoded to the lowest matching entry.

module ram_dp_ip #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   output logic [DATA_WIDTH-1:0] a_dout,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic                  b_we,
   input  logic [DATA_WIDTH-1:0] b_din,
   output logic [DATA_WIDTH-1:0] b_dout
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] a_dout_q;
   logic [DATA_WIDTH-1:0] b_dout_q;

   // read-first on port B so read-modify-write sees the pre-write word
   always_ff @(posedge clk) begin
      a_dout_q <= mem[a_addr];
      b_dout_q <= mem[b_addr];
      if (b_we) mem[b_addr] <= b_din;
   end

   assign a_dout = a_dout_q;
   assign b_dout = b_dout_q;
endmodule

module priority_encoder #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]      input_bits,
   output logic                  output_valid,
   output logic [ADDR_WIDTH-1:0] output_addr,
   output logic [WIDTH-1:0]      output_single
);
   always_comb begin
      output_addr = '0;
      for (int i = WIDTH-1; i >= 0; i--) begin
         if (input_bits[i]) output_addr = ADDR_WIDTH'(i);
      end
      output_valid  = |input_bits;
      output_single = output_valid ? (WIDTH'(1) << output_addr) : '0;
   end
endmodule

// state    | meaning
// INIT     | clearing every slice word, count runs down to 0
// IDLE     | latching write request, waiting for write_enable
// DELETE_1 | waiting for erase RAM and port B read of the old key
// DELETE_2 | clearing the entry bit at the old key
// WRITE_1  | waiting for port B read of the new key
// WRITE_2  | setting the entry bit at the new key
module bram_cam #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 5,
   parameter int SLICE_WIDTH = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   write_addr,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic                    write_delete,
   input  logic                    write_enable,
   output logic                    write_busy,
   input  logic [DATA_WIDTH-1:0]   compare_data,
   output logic [2**ADDR_WIDTH-1:0] match_many,
   output logic [2**ADDR_WIDTH-1:0] match_single,
   output logic [ADDR_WIDTH-1:0]   match_addr,
   output logic                    match
);
   localparam int RAM_DEPTH   = 2**ADDR_WIDTH;
   localparam int SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;

   typedef enum logic [2:0] {INIT, IDLE, DELETE_1, DELETE_2, WRITE_1, WRITE_2} state_t;

   state_t                 state_q, state_d;
   logic [SLICE_WIDTH-1:0] count_q, count_d;
   logic [ADDR_WIDTH-1:0]  write_addr_q, write_addr_d;
   logic [DATA_WIDTH-1:0]  write_data_q, write_data_d;
   logic                   write_delete_q, write_delete_d;
   logic                   write_busy_q;
   logic                   erase_we;

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      write_addr_d   = write_addr_q;
      write_data_d   = write_data_q;
      write_delete_d = write_delete_q;
      erase_we       = 1'b0;
      case (state_q)
         INIT: begin
            count_d = count_q - 1'b1;
            if (count_q == '0) state_d = IDLE;
         end
         IDLE: begin
            write_addr_d   = write_addr;
            write_data_d   = write_data;
            write_delete_d = write_delete;
            if (write_enable) state_d = DELETE_1;
         end
         DELETE_1: state_d = DELETE_2;
         DELETE_2: begin
            if (write_delete_q) begin
               state_d = IDLE;
            end else begin
               erase_we = 1'b1;
               state_d  = WRITE_1;
            end
         end
         WRITE_1: state_d = WRITE_2;
         WRITE_2: state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= INIT;
         count_q        <= '1;
         write_busy_q   <= 1'b1;
         write_addr_q   <= '0;
         write_data_q   <= '0;
         write_delete_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         write_busy_q   <= (state_d != IDLE);
         write_addr_q   <= write_addr_d;
         write_data_q   <= write_data_d;
         write_delete_q <= write_delete_d;
      end
   end

   assign write_busy = write_busy_q;

   // Erase RAM: key held per entry, read at the address being latched so the
   // old key is ready in DELETE_1. Also zeroed during INIT.
   logic                  init_st;
   logic [ADDR_WIDTH-1:0] erase_waddr;
   logic [DATA_WIDTH-1:0] erase_mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] erase_dout_q;

   assign init_st     = (state_q == INIT);
   assign erase_waddr = init_st ? ADDR_WIDTH'(count_q) : write_addr_q;

   always_ff @(posedge clk) begin
      if (init_st || erase_we) erase_mem[erase_waddr] <= init_st ? '0 : write_data_q;
      erase_dout_q <= erase_mem[write_addr_d];
   end

   logic [DATA_WIDTH-1:0] b_key;
   logic [RAM_DEPTH-1:0]  clear_bit;
   logic [RAM_DEPTH-1:0]  set_bit;
   logic                  b_we;

   assign b_key     = (state_q == WRITE_1 || state_q == WRITE_2) ? write_data_q : erase_dout_q;
   assign clear_bit = (state_q == DELETE_2) ? (RAM_DEPTH'(1) << write_addr_q) : '0;
   assign set_bit   = (state_q == WRITE_2)  ? (RAM_DEPTH'(1) << write_addr_q) : '0;
   assign b_we      = init_st || state_q == DELETE_2 || state_q == WRITE_2;

   logic [RAM_DEPTH-1:0] slice_match [SLICE_COUNT];

   for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_slice
      localparam int W = (s == SLICE_COUNT-1) ? DATA_WIDTH - SLICE_WIDTH*(SLICE_COUNT-1)
                                              : SLICE_WIDTH;
      logic [W-1:0]         b_addr;
      logic [RAM_DEPTH-1:0] b_dout;
      logic [RAM_DEPTH-1:0] b_din;
      logic [RAM_DEPTH-1:0] a_dout;

      assign b_addr = init_st ? count_q[W-1:0] : b_key[s*SLICE_WIDTH +: W];
      assign b_din  = init_st ? '0 : ((b_dout & ~clear_bit) | set_bit);

      ram_dp_ip #(
         .DATA_WIDTH(RAM_DEPTH),
         .ADDR_WIDTH(W)
      ) ram_inst (
         .clk   (clk),
         .a_addr(compare_data[s*SLICE_WIDTH +: W]),
         .a_dout(a_dout),
         .b_addr(b_addr),
         .b_we  (b_we),
         .b_din (b_din),
         .b_dout(b_dout)
      );

      assign slice_match[s] = a_dout;
   end

   always_comb begin
      match_many = '1;
      for (int s = 0; s < SLICE_COUNT; s++) match_many &= slice_match[s];
   end

   priority_encoder #(
      .WIDTH     (RAM_DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) enc_inst (
      .input_bits   (match_many),
      .output_valid (match),
      .output_addr  (match_addr),
      .output_single(match_single)
   );
endmodule

// File: tb/tb_bram_cam.sv
// Bench for bram_cam: a key-per-entry model checked every idle cycle, plus
// directed lookups with literal expectations.

module tb_bram_cam;
   localparam int DW = 64;
   localparam int AW = 5;
   localparam int ND = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] write_addr = '0;
   logic [DW-1:0] write_data = '0;
   logic          write_delete = 1'b0;
   logic          write_enable = 1'b0;
   logic          write_busy;
   logic [DW-1:0] compare_data = '0;
   logic [ND-1:0] match_many;
   logic [ND-1:0] match_single;
   logic [AW-1:0] match_addr;
   logic          match;

   bram_cam dut (
      .clk         (clk),
      .rst         (rst),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .write_delete(write_delete),
      .write_enable(write_enable),
      .write_busy  (write_busy),
      .compare_data(compare_data),
      .match_many  (match_many),
      .match_single(match_single),
      .match_addr  (match_addr),
      .match       (match)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model: the key stored at each entry, and whether the entry is live
   logic [DW-1:0] mkey [ND];
   logic          mval [ND];
   logic          chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [ND-1:0] model_many(input logic [DW-1:0] k);
      logic [ND-1:0] r;
      r = '0;
      for (int i = 0; i < ND; i++) if (mval[i] && mkey[i] == k) r[i] = 1'b1;
      return r;
   endfunction

   function automatic int lowest(input logic [ND-1:0] m);
      for (int i = 0; i < ND; i++) if (m[i]) return i;
      return 0;
   endfunction

   logic          exp_v = 1'b0;
   logic [ND-1:0] exp_many;

   always @(posedge clk) begin
      exp_v    <= chk_en && !rst;
      exp_many <= model_many(compare_data);
   end

   always @(negedge clk) begin
      if (exp_v) begin
         check("model many", 64'(match_many), 64'(exp_many));
         check("model match", 64'(match), 64'(|exp_many));
         check("model addr", 64'(match_addr), 64'(lowest(exp_many)));
         check("model single", 64'(match_single),
               (|exp_many) ? (64'd1 << lowest(exp_many)) : 64'd0);
      end
   end

   task automatic lookup(input string nm, input logic [DW-1:0] k, input logic [ND-1:0] em,
                         input logic [AW-1:0] ea, input logic [ND-1:0] es);
      compare_data = k;
      @(negedge clk);
      check({nm, " many"}, 64'(match_many), 64'(em));
      check({nm, " addr"}, 64'(match_addr), 64'(ea));
      check({nm, " single"}, 64'(match_single), 64'(es));
      check({nm, " match"}, 64'(match), 64'(em != '0));
   endtask

   task automatic do_op(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic del,
                        output int busy_n);
      chk_en       = 1'b0;
      write_addr   = a;
      write_data   = d;
      write_delete = del;
      write_enable = 1'b1;
      @(negedge clk);
      write_enable = 1'b0;
      busy_n = 0;
      while (write_busy && busy_n < 50) begin
         busy_n++;
         @(negedge clk);
      end
      if (del) mval[a] = 1'b0;
      else begin
         mval[a] = 1'b1;
         mkey[a] = d;
      end
      chk_en = 1'b1;
   endtask

   task automatic count_init(output int n);
      n = 0;
      while (write_busy && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   int n;
   logic [DW-1:0] sweep [7];

   initial begin
      for (int i = 0; i < ND; i++) begin
         mval[i] = 1'b0;
         mkey[i] = '0;
      end
      sweep = '{64'h1234, 64'h5678, 64'hAAAA, 64'h0, {DW{1'b1}}, 64'h5679, 64'h1235};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      count_init(n);
      check("init busy cycles", 64'(n), 64'd512);
      chk_en = 1'b1;

      lookup("empty 1234", 64'h1234, 32'h0, 5'd0, 32'h0);
      lookup("empty 0", 64'h0, 32'h0, 5'd0, 32'h0);

      do_op(5'd3, 64'h1234, 1'b0, n);
      check("write busy cycles", 64'(n), 64'd4);
      lookup("a3 1234", 64'h1234, 32'h0000_0008, 5'd3, 32'h0000_0008);

      do_op(5'd1, 64'h1234, 1'b0, n);
      lookup("a1a3 1234", 64'h1234, 32'h0000_000A, 5'd1, 32'h0000_0002);

      do_op(5'd3, 64'h5678, 1'b0, n);
      lookup("ovw 1234", 64'h1234, 32'h0000_0002, 5'd1, 32'h0000_0002);
      lookup("ovw 5678", 64'h5678, 32'h0000_0008, 5'd3, 32'h0000_0008);

      do_op(5'd1, 64'h0, 1'b1, n);
      check("delete busy cycles", 64'(n), 64'd2);
      lookup("del 1234", 64'h1234, 32'h0, 5'd0, 32'h0);

      // second request during busy must be dropped
      chk_en       = 1'b0;
      write_addr   = 5'd5;
      write_data   = 64'hAAAA;
      write_delete = 1'b0;
      write_enable = 1'b1;
      @(negedge clk);
      write_addr   = 5'd6;
      write_data   = 64'hBBBB;
      @(negedge clk);
      write_enable = 1'b0;
      n = 0;
      while (write_busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("busy after ignored req", 64'(write_busy), 64'd0);
      mval[5] = 1'b1;
      mkey[5] = 64'hAAAA;
      chk_en  = 1'b1;
      lookup("ignored BBBB", 64'hBBBB, 32'h0, 5'd0, 32'h0);
      lookup("kept AAAA", 64'hAAAA, 32'h0000_0020, 5'd5, 32'h0000_0020);

      do_op(5'd31, {DW{1'b1}}, 1'b0, n);
      do_op(5'd0, 64'h0, 1'b0, n);
      lookup("a31 ones", {DW{1'b1}}, 32'h8000_0000, 5'd31, 32'h8000_0000);
      lookup("a0 zero", 64'h0, 32'h0000_0001, 5'd0, 32'h0000_0001);

      do_op(5'd7, 64'h0, 1'b1, n);
      lookup("del unwritten", 64'h0, 32'h0000_0001, 5'd0, 32'h0000_0001);

      do_op(5'd2, 64'h5678, 1'b0, n);
      lookup("dup 5678", 64'h5678, 32'h0000_000C, 5'd2, 32'h0000_0004);

      for (int i = 0; i < 7; i++) begin
         compare_data = sweep[i];
         @(negedge clk);
      end
      @(negedge clk);

      // reset in WRITE_1 aborts and clears everything
      chk_en       = 1'b0;
      write_addr   = 5'd9;
      write_data   = 64'hCAFE;
      write_delete = 1'b0;
      write_enable = 1'b1;
      @(negedge clk);
      write_enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_init(n);
      check("reinit busy cycles", 64'(n), 64'd512);
      for (int i = 0; i < ND; i++) mval[i] = 1'b0;
      chk_en = 1'b1;
      lookup("rst 5678", 64'h5678, 32'h0, 5'd0, 32'h0);
      lookup("rst AAAA", 64'hAAAA, 32'h0, 5'd0, 32'h0);
      lookup("rst ones", {DW{1'b1}}, 32'h0, 5'd0, 32'h0);
      lookup("rst CAFE", 64'hCAFE, 32'h0, 5'd0, 32'h0);
      lookup("rst 0", 64'h0, 32'h0, 5'd0, 32'h0);

      chk_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bram_cam.md
# bram_cam

Block-RAM based content-addressable memory with 2^ADDR_WIDTH entries of DATA_WIDTH bits. The search key is split into SLICE_WIDTH-bit slices, each indexing a dual-port RAM (instance `ram_dp_ip`) whose words are per-entry match bitmaps. The slice bitmaps are ANDed together, and a `priority_encoder` reduces the result to a single lowest-index hit. The block sits in the L2 switch as the MAC lookup table: the learning logic writes entries, and the forwarding path compares keys.

## Interface
Reset `rst` is synchronous and active-high; clock is `clk`.

Parameters:
- DATA_WIDTH, 64, search key width
- ADDR_WIDTH, 5, log2 of entry count (RAM_DEPTH = 2^ADDR_WIDTH)
- SLICE_WIDTH, 9, key bits per RAM slice; SLICE_COUNT = ceil(DATA_WIDTH/SLICE_WIDTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- write_addr  in  ADDR_WIDTH  entry to write or delete
- write_data  in  DATA_WIDTH  key to store
- write_delete  in  1  1 = delete entry, 0 = write entry
- write_enable  in  1  start a write/delete; sampled only when idle
- write_busy  out  1  1 = initialising or executing an operation
- compare_data  in  DATA_WIDTH  search key
- match_many  out  RAM_DEPTH  bitmap of all matching entries
- match_single  out  RAM_DEPTH  one-hot of the lowest matching entry, 0 if none
- match_addr  out  ADDR_WIDTH  index of the lowest matching entry, 0 if none
- match  out  1  at least one entry matches

## Operation
- Slice s covers key bits [s*SLICE_WIDTH +: W].
  - W = SLICE_WIDTH for every slice except the last.
  - The last slice uses W = DATA_WIDTH - SLICE_WIDTH*(SLICE_COUNT-1).
  - Each slice RAM holds 2^W words of RAM_DEPTH bits.
- Port A of each slice is the compare port.
  - It does a registered read at the compare_data slice.
  - match_many = AND over all slices of the port-A output.
- Port B of each slice is the maintenance port.
  - It performs read-modify-write: new word = (read & ~clear_bit) | set_bit.
- Erase RAM: a RAM_DEPTH x DATA_WIDTH memory holding the key currently stored per entry.
  - Initialised to 0.
  - Read every cycle at the latched write address.
  - Written with the new key during a write.
- priority_encoder, LSB priority, purely combinational on match_many:
  - match = |match_many.
  - match_addr = lowest set index.
  - match_single = 1 << match_addr.
  - When match_many = 0: match_addr = 0 and match_single = 0.
- FSM states: INIT, IDLE, DELETE_1, DELETE_2, WRITE_1, WRITE_2.
  - INIT: count runs from 2^SLICE_WIDTH-1 down to 0. Each cycle, write 0 to word `count` (truncated to W) of every slice. When count = 0, go to IDLE.
  - IDLE: latch write_addr, write_data and write_delete every cycle. If write_enable = 1, go to DELETE_1.
  - DELETE_1: wait one cycle for the erase RAM and port B reads.
  - DELETE_2: port B address = old key from the erase RAM; clear bit write_addr_reg; write back. If delete, go to IDLE. Otherwise write the new key into the erase RAM and go to WRITE_1.
  - WRITE_1: wait one cycle for the read at the new key.
  - WRITE_2: port B address = new key; set bit write_addr_reg; write back; go to IDLE.
- Writing an entry therefore removes its old key before inserting the new one.
- Deleting a never-written entry clears its bit at key 0, which is harmless.
- Identical keys stored at several entries all appear in match_many.
- write_enable is ignored whenever the FSM is not in IDLE; no queueing.

## Timing
- Reset: state = INIT, count = all ones, write_busy = 1.
  - match outputs follow RAM contents and are not reset.
  - rst mid-operation aborts the operation and re-clears all slices.
- write_busy is registered as (next_state != IDLE).
  - It stays high for 2^SLICE_WIDTH INIT cycles (512 by default).
  - It rises the cycle after write_enable is accepted.
- Operation length from the accepting IDLE cycle:
  - Write: 4 busy cycles, then IDLE.
  - Delete: 2 busy cycles, then IDLE.
- Compare latency: match_many, match, match_addr and match_single are valid 1 clock after compare_data is presented.
- A compare issued in the cycle a WRITE_2 or DELETE_2 write-back occurs sees the pre-update contents.
- Compares in flight during a write may see the intermediate state (old key removed, new key not yet inserted).

## Test plan
- Reset -> write_busy = 1 for exactly 512 cycles, then 0; compare any key -> match = 0, match_many = 0, match_addr = 0, match_single = 0.
- Write addr 3 = 0x1234, wait for !busy; compare 0x1234 -> next cycle match = 1, match_addr = 3, match_single = 0x00000008, match_many = 0x00000008.
- Additionally write addr 1 = 0x1234 -> match_many = 0x0000000A, match_addr = 1, match_single = 0x00000002.
- Overwrite addr 3 with 0x5678 -> compare 0x1234 gives match_many = 0x00000002; compare 0x5678 gives match_many = 0x00000008.
- Delete addr 1, then compare 0x1234 -> match = 0; pulse write_enable while busy -> request ignored, contents unchanged.
- Assert rst during WRITE_1 -> busy stays high for 512 cycles; afterwards all previously stored keys miss.
